lsu_pipelined: RTL and testbench

- Pipelined load/store unit for one SPU-style core with a private local store (LS) of LS_DEPTH quadword lines.
- Executes LQD, LQX, STQD, STQX, LNOP, and load-link/store-conditional (LL/SC).
- Keeps a single-line reservation that a snoop port clears; other cores in the multi-core array drive that port on their stores.
- Results return after a fixed, parametrised latency with a destination tag for register-file writeback.

---
 rtl/lsu_pipelined_pkg.sv | 27 ++
 rtl/lsu_pipelined_if.sv | 35 +++
 rtl/lsu_pipelined_local_store.sv | 27 ++
 rtl/lsu_pipelined.sv | 185 ++++++++++++++++++
 tb/tb_lsu_pipelined.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pipelined_pkg.sv
// Opcode constants, op encoding and the stage record shared by the load/store unit.
// The LSU_* widths size the stage registers and must match the top-level parameters.
package lsu_pkg;

  localparam int LSU_DATA_W = 128;
  localparam int LSU_TAG_W  = 7;
  localparam int LSU_LINE_W = 11;

  localparam logic [7:0]  OP_LQD_PFX  = 8'b00110100;
  localparam logic [7:0]  OP_STQD_PFX = 8'b00100100;
  localparam logic [10:0] OP_LQX      = 11'b00111000100;
  localparam logic [10:0] OP_STQX     = 11'b00101000100;
  localparam logic [10:0] OP_LNOP     = 11'b00000000001;
  localparam logic [10:0] OP_LL       = 11'b10101100000;
  localparam logic [10:0] OP_SC       = 11'b10101000000;

  typedef enum logic [2:0] {NOP, LOAD, STORE, LL, SC} lsu_op_e;

  typedef struct packed {
    logic                  valid;
    lsu_op_e               op;
    logic [LSU_LINE_W-1:0] line;
    logic [LSU_DATA_W-1:0] data;
    logic [LSU_TAG_W-1:0]  tag;
  } lsu_stage_t;

endpackage

// File: rtl/lsu_pipelined_if.sv
// Issue, snoop and writeback signals of the load/store unit; the core drives master, the LSU is slave.
// No flow control: the unit accepts an op every cycle and results are strobed without backpressure.
interface lsu_pipelined_if
  import lsu_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = LSU_TAG_W
);
  logic              in_valid;
  logic [10:0]       opcode;
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] rb;
  logic [DATA_W-1:0] rc;
  logic [9:0]        immediate;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              snoop_valid;
  logic [ADDR_W-1:0] snoop_addr;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic [TAG_W-1:0]  result_tag;
  logic              write_signal;
  logic              resv_valid;

  modport master (
    output in_valid, opcode, ra, rb, rc, immediate, in_tag, flush, snoop_valid, snoop_addr,
    input  result, result_valid, result_tag, write_signal, resv_valid
  );

  modport slave (
    input  in_valid, opcode, ra, rb, rc, immediate, in_tag, flush, snoop_valid, snoop_addr,
    output result, result_valid, result_tag, write_signal, resv_valid
  );
endinterface

// File: rtl/lsu_pipelined_local_store.sv
// Single-port quadword local store, write-first; read data is registered (1 cycle).
// No backpressure: one access per cycle, contents are never reset.
module lsu_local_store #(
  parameter int DATA_W   = 128,
  parameter int LS_DEPTH = 2048,
  localparam int AW      = $clog2(LS_DEPTH)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [LS_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
      rdata_q     <= wdata_i;
    end else begin
      rdata_q     <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/lsu_pipelined.sv
// Pipelined SPU-style load/store unit with LL/SC reservation; result LATENCY cycles after issue.
// Never stalls: an op is accepted every cycle and flush only kills the op entering stage 1.
module lsu_pipelined
  import lsu_pkg::*;
#(
  parameter int DATA_W   = LSU_DATA_W,
  parameter int ADDR_W   = 32,
  parameter int LS_DEPTH = 2048,
  parameter int LATENCY  = 4,
  parameter int TAG_W    = LSU_TAG_W
) (
  input logic            clk,
  input logic            reset,
  lsu_pipelined_if.slave bus
);
  localparam int LINE_W = $clog2(LS_DEPTH);
  localparam logic [DATA_W-1:0] SC_OK_WORD = {{(DATA_W-1){1'b0}}, 1'b1} << (DATA_W-32);

  lsu_stage_t s1_d, s1_q, s2_d, s2_q;
  lsu_op_e    op_dec;
  logic       dform;
  logic       resv_valid_d, resv_valid_q;
  logic [LINE_W-1:0] resv_line_d, resv_line_q, snoop_line;
  logic       sc_ok, ls_we, snoop_hit;
  logic [DATA_W-1:0] ls_rdata;

  // The address comes from the preferred slot, zero-extended or truncated to ADDR_W.
  logic [ADDR_W+31:0] ra_ext, rb_ext;
  logic [ADDR_W+13:0] imm_ext;
  logic [ADDR_W-1:0]  ea;

  assign ra_ext  = {{ADDR_W{1'b0}}, bus.ra[DATA_W-1 -: 32]};
  assign rb_ext  = {{ADDR_W{1'b0}}, bus.rb[DATA_W-1 -: 32]};
  assign imm_ext = {{ADDR_W{bus.immediate[9]}}, bus.immediate, 4'b0000};
  assign ea      = dform ? ra_ext[ADDR_W-1:0] + imm_ext[ADDR_W-1:0]
                         : ra_ext[ADDR_W-1:0] + rb_ext[ADDR_W-1:0];

  always_comb begin
    op_dec = NOP;
    dform  = 1'b0;
    if (bus.opcode[10:3] == OP_LQD_PFX) begin
      op_dec = LOAD;
      dform  = 1'b1;
    end else if (bus.opcode[10:3] == OP_STQD_PFX) begin
      op_dec = STORE;
      dform  = 1'b1;
    end else begin
      case (bus.opcode)
        OP_LQX:  op_dec = LOAD;
        OP_STQX: op_dec = STORE;
        OP_LL:   op_dec = LL;
        OP_SC:   op_dec = SC;
        OP_LNOP: op_dec = NOP;
        default: op_dec = NOP;
      endcase
    end
  end

  always_comb begin
    s1_d       = '0;
    s1_d.valid = bus.in_valid && !bus.flush;
    s1_d.op    = op_dec;
    s1_d.line  = ea[4 +: LINE_W];
    s1_d.data  = bus.rc;
    s1_d.tag   = bus.in_tag;
  end

  assign snoop_line = bus.snoop_addr[4 +: LINE_W];
  assign snoop_hit  = bus.snoop_valid && resv_valid_q && (snoop_line == resv_line_q);

  // Clears are applied first; an LL only claims its line if no snoop hits that line this cycle.
  always_comb begin
    resv_valid_d = resv_valid_q;
    resv_line_d  = resv_line_q;
    sc_ok        = 1'b0;
    if (snoop_hit) resv_valid_d = 1'b0;
    if (s1_q.valid) begin
      case (s1_q.op)
        STORE: if (s1_q.line == resv_line_q) resv_valid_d = 1'b0;
        SC: begin
          sc_ok        = resv_valid_q && (s1_q.line == resv_line_q) && !snoop_hit;
          resv_valid_d = 1'b0;
        end
        LL: begin
          if (!(bus.snoop_valid && snoop_line == s1_q.line)) begin
            resv_valid_d = 1'b1;
            resv_line_d  = s1_q.line;
          end
        end
        default: ;
      endcase
    end
  end

  assign ls_we = s1_q.valid && ((s1_q.op == STORE) || (s1_q.op == SC && sc_ok));

  lsu_local_store #(.DATA_W(DATA_W), .LS_DEPTH(LS_DEPTH)) u_ls (
    .clk     (clk),
    .addr_i  (s1_q.line),
    .we_i    (ls_we),
    .wdata_i (s1_q.data),
    .rdata_o (ls_rdata)
  );

  always_comb begin
    s2_d = '0;
    if (s1_q.valid && (s1_q.op == LOAD || s1_q.op == LL || s1_q.op == SC)) begin
      s2_d.valid = 1'b1;
      s2_d.op    = s1_q.op;
      s2_d.tag   = s1_q.tag;
      s2_d.data  = sc_ok ? SC_OK_WORD : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      resv_valid_q <= 1'b0;
      resv_line_q  <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      resv_valid_q <= resv_valid_d;
      resv_line_q  <= resv_line_d;
    end
  end

  logic              r2_vld, out_vld;
  logic [TAG_W-1:0]  r2_tag, out_tag;
  logic [DATA_W-1:0] r2_dat, out_dat;

  assign r2_vld = s2_q.valid;
  assign r2_tag = s2_q.tag;
  assign r2_dat = !s2_q.valid ? '0 : ((s2_q.op == SC) ? s2_q.data : ls_rdata);

  generate
    if (LATENCY == 2) begin : g_no_dly
      assign out_vld = r2_vld;
      assign out_tag = r2_tag;
      assign out_dat = r2_dat;
    end else begin : g_dly
      localparam int N = LATENCY - 2;
      logic [N-1:0]      vld_q;
      logic [TAG_W-1:0]  tag_q [N];
      logic [DATA_W-1:0] dat_q [N];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld_q <= '0;
          for (int i = 0; i < N; i++) begin
            tag_q[i] <= '0;
            dat_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= r2_vld;
          tag_q[0] <= r2_tag;
          dat_q[0] <= r2_dat;
          for (int i = 1; i < N; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign out_vld = vld_q[N-1];
      assign out_tag = tag_q[N-1];
      assign out_dat = dat_q[N-1];
    end
  endgenerate

  assign bus.result       = out_dat;
  assign bus.result_valid = out_vld;
  assign bus.result_tag   = out_tag;
  assign bus.write_signal = out_vld;
  assign bus.resv_valid   = resv_valid_q;

  // Only the preferred slot and the line-index bits of addresses carry meaning.
  logic unused_ok;
  assign unused_ok = ^{bus.ra[DATA_W-33:0], bus.rb[DATA_W-33:0], ra_ext[ADDR_W+31:ADDR_W],
                       rb_ext[ADDR_W+31:ADDR_W], imm_ext[ADDR_W+13:ADDR_W], ea[3:0],
                       ea[ADDR_W-1:LINE_W+4], bus.snoop_addr[3:0],
                       bus.snoop_addr[ADDR_W-1:LINE_W+4], s2_q.line};
endmodule

// File: tb/tb_lsu_pipelined.sv
// Randomised scoreboard bench for lsu_pipelined against a sequential local-store/reservation model.
module tb_lsu_pipelined;
  localparam int DW = 128, AW = 32, DEPTH = 2048, LAT = 4, TW = 7;

  localparam logic [10:0] C_LQD  = 11'b00110100000;
  localparam logic [10:0] C_STQD = 11'b00100100000;
  localparam logic [10:0] C_LQX  = 11'b00111000100;
  localparam logic [10:0] C_STQX = 11'b00101000100;
  localparam logic [10:0] C_LNOP = 11'b00000000001;
  localparam logic [10:0] C_LL   = 11'b10101100000;
  localparam logic [10:0] C_SC   = 11'b10101000000;
  localparam logic [10:0] C_JUNK = 11'b11111111111;

  localparam int K_NOP = 0, K_LD = 1, K_ST = 2, K_LL = 3, K_SC = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsu_pipelined_if #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) bus ();
  lsu_pipelined #(.DATA_W(DW), .ADDR_W(AW), .LS_DEPTH(DEPTH), .LATENCY(LAT), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  typedef struct {
    bit           v;
    int           kind;
    int           line;
    logic [127:0] dat;
    logic [6:0]   tag;
    int           due;
  } mop_t;

  typedef struct {
    logic [127:0] dat;
    logic [6:0]   tag;
    int           due;
  } exp_t;

  logic [127:0] m_ls [DEPTH];
  bit   m_rv = 0;
  int   m_rl = 0;
  mop_t pend;
  exp_t sbq[$];
  exp_t mon_e;

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 4) & 32'(DEPTH - 1));
  endfunction

  // Applies the op issued last cycle together with this cycle's snoop, in program order.
  task automatic model_apply(input bit sv, input logic [31:0] sa);
    bit hit, ok;
    int sl;
    sl  = line_of(sa);
    hit = sv && m_rv && (sl == m_rl);
    if (hit) m_rv = 0;
    if (pend.v) begin
      case (pend.kind)
        K_LD: sbq.push_back('{m_ls[pend.line], pend.tag, pend.due});
        K_ST: begin
          m_ls[pend.line] = pend.dat;
          if (m_rv && pend.line == m_rl) m_rv = 0;
        end
        K_LL: begin
          sbq.push_back('{m_ls[pend.line], pend.tag, pend.due});
          if (!(sv && sl == pend.line)) begin
            m_rv = 1;
            m_rl = pend.line;
          end
        end
        K_SC: begin
          ok = m_rv && (m_rl == pend.line);
          if (ok) m_ls[pend.line] = pend.dat;
          sbq.push_back('{ok ? (128'(1) << 96) : 128'(0), pend.tag, pend.due});
          m_rv = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic [10:0] opc, input logic [31:0] ra_s, input logic [31:0] rb_s,
                      input logic [9:0] imm, input logic [127:0] rc, input logic [6:0] tag,
                      input bit iv, input bit fl, input bit sv, input logic [31:0] sa);
    int simm, kind;
    bit dform;
    logic [31:0] ea;
    @(posedge clk);
    #1;
    chk("resv_valid", 128'(bus.resv_valid), 128'(m_rv));
    bus.in_valid    = iv;
    bus.opcode      = opc;
    bus.ra          = {ra_s, $urandom(), $urandom(), $urandom()};
    bus.rb          = {rb_s, $urandom(), $urandom(), $urandom()};
    bus.rc          = rc;
    bus.immediate   = imm;
    bus.in_tag      = tag;
    bus.flush       = fl;
    bus.snoop_valid = sv;
    bus.snoop_addr  = sa;
    model_apply(sv, sa);
    dform = 0;
    kind  = K_NOP;
    if (opc[10:3] == C_LQD[10:3]) begin kind = K_LD; dform = 1; end
    else if (opc[10:3] == C_STQD[10:3]) begin kind = K_ST; dform = 1; end
    else if (opc == C_LQX)  kind = K_LD;
    else if (opc == C_STQX) kind = K_ST;
    else if (opc == C_LL)   kind = K_LL;
    else if (opc == C_SC)   kind = K_SC;
    simm = int'($signed(imm));
    ea   = dform ? ra_s + 32'(simm * 16) : ra_s + rb_s;
    pend = '{(iv && !fl && kind != K_NOP), kind, line_of(ea), rc, tag, cyc + LAT};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(C_LNOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Result monitor: pops the oldest expectation whenever the unit strobes a writeback.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.result_valid) begin
        if (sbq.size() == 0) chk("unexpected_result", 128'(bus.result_valid), 128'(0));
        else begin
          mon_e = sbq.pop_front();
          chk("result_cycle", 128'(cyc), 128'(mon_e.due));
          chk("result_data", bus.result, mon_e.dat);
          chk("result_tag", 128'(bus.result_tag), 128'(mon_e.tag));
          chk("write_signal", 128'(bus.write_signal), 128'(1));
        end
      end else begin
        chk("idle_result_zero", bus.result, 128'(0));
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
          chk("result_missing", 128'(cyc), 128'(sbq[0].due));
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] addr, ra_s, rb_s, sa;
    logic [9:0]  imm;
    logic [10:0] opc;
    int          ln, pick, simm;
    bit          fl, sv;

    pend = '{0, K_NOP, 0, 128'(0), 7'(0), 0};
    bus.in_valid = 0; bus.opcode = C_LNOP; bus.ra = '0; bus.rb = '0; bus.rc = '0;
    bus.immediate = '0; bus.in_tag = '0; bus.flush = 0; bus.snoop_valid = 0; bus.snoop_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_result_valid", 128'(bus.result_valid), 128'(0));
    chk("reset_result", bus.result, 128'(0));
    chk("reset_result_tag", 128'(bus.result_tag), 128'(0));
    chk("reset_write_signal", 128'(bus.write_signal), 128'(0));
    chk("reset_resv_valid", 128'(bus.resv_valid), 128'(0));
    @(negedge clk) reset = 1'b1;

    for (int l = 0; l < 64; l++)
      step(C_STQX, 32'(l * 16), 0, 0, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1, 0, 0, 0);

    step(C_STQD, 32'h100, 0, 10'd1, {4{32'hA5A5A5A5}}, 7'h11, 1, 0, 0, 0);
    step(C_LQD, 32'h110, 0, 10'd0, 0, 7'h22, 1, 0, 0, 0);
    step(C_LQX, 32'h7, 32'h18, 0, 0, 7'h03, 1, 0, 0, 0);
    step(C_STQX, 32'h50, 0, 0, {4{32'h5EEDF00D}}, 0, 1, 0, 0, 0);
    step(C_LQX, 32'h50, 0, 0, 0, 7'h05, 1, 0, 0, 0);

    step(C_LL, 32'h200, 0, 0, 0, 7'h30, 1, 0, 0, 0);
    step(C_SC, 32'h200, 0, 0, 128'h1234, 7'h31, 1, 0, 0, 0);
    step(C_LQX, 32'h200, 0, 0, 0, 7'h32, 1, 0, 0, 0);
    idle(2);
    chk("resv_cleared_by_sc", 128'(bus.resv_valid), 128'(0));

    step(C_LL, 32'h200, 0, 0, 0, 7'h40, 1, 0, 0, 0);
    idle(2);
    chk("resv_set_by_ll", 128'(bus.resv_valid), 128'(1));
    step(C_LNOP, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20C);
    idle(1);
    chk("resv_cleared_by_snoop", 128'(bus.resv_valid), 128'(0));
    step(C_SC, 32'h200, 0, 0, 128'hDEAD, 7'h41, 1, 0, 0, 0);
    step(C_LQX, 32'h200, 0, 0, 0, 7'h42, 1, 0, 0, 0);

    step(C_STQD, 32'h3F0, 0, 0, {4{32'hBADBAD00}}, 0, 1, 1, 0, 0);
    step(C_LQD, 32'h3F0, 0, 0, 0, 7'h50, 1, 0, 0, 0);
    step(C_STQD, 32'h3E0, 0, 0, {4{32'hC0FFEE00}}, 0, 1, 0, 0, 0);
    step(C_LQD, 32'h3F0, 0, 0, 0, 7'h51, 1, 1, 0, 0);
    step(C_LQD, 32'h3E0, 0, 0, 0, 7'h52, 1, 0, 0, 0);
    idle(LAT + 2);

    step(C_LL, 32'h300, 0, 0, 0, 7'h60, 1, 0, 0, 0);
    step(C_LQD, 32'h300, 0, 0, 0, 7'h61, 1, 0, 0, 0);
    idle(3);
    @(posedge clk);
    #2;
    chk("pre_reset_result_valid", 128'(bus.result_valid), 128'(1));
    chk("pre_reset_resv_valid", 128'(bus.resv_valid), 128'(1));
    reset = 1'b0;
    #1;
    chk("async_reset_result_valid", 128'(bus.result_valid), 128'(0));
    chk("async_reset_resv_valid", 128'(bus.resv_valid), 128'(0));
    sbq.delete();
    pend.v = 0;
    m_rv   = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(LAT + 4);

    for (int n = 0; n < 600; n++) begin
      pick = int'($urandom_range(0, 7));
      case (pick)
        0: opc = C_LQD;  1: opc = C_LQX;  2: opc = C_STQD; 3: opc = C_STQX;
        4: opc = C_LL;   5: opc = C_SC;   6: opc = C_LNOP; default: opc = C_JUNK;
      endcase
      ln   = int'($urandom_range(0, 15));
      addr = ($urandom() & 32'hFFFF8000) | 32'(ln << 4) | 32'($urandom_range(0, 15));
      imm  = 10'($urandom());
      simm = int'($signed(imm));
      if (opc == C_LQD || opc == C_STQD) begin
        ra_s = addr - 32'(simm * 16);
        rb_s = $urandom();
      end else begin
        ra_s = $urandom();
        rb_s = addr - ra_s;
      end
      fl = ($urandom_range(0, 7) == 0);
      sv = ($urandom_range(0, 3) == 0);
      sa = ($urandom() & 32'hFFFF8000) | 32'($urandom_range(0, 15) << 4) | 32'($urandom_range(0, 15));
      step(opc, ra_s, rb_s, imm, {$urandom(), $urandom(), $urandom(), $urandom()},
           7'($urandom()), ($urandom_range(0, 5) != 0), fl, sv, sa);
    end

    idle(LAT + 4);
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
